// File: rtl/mult_div_unit_if.sv
// Decode/hazard-side bundle for the HI/LO multiply/divide unit.
// Decode drives the master side; the unit itself is the slave.
interface mult_div_unit_if #(
  parameter int unsigned WORD_LEN = 32
);
  logic                start;
  logic [1:0]          op;
  logic [WORD_LEN-1:0] val1;
  logic [WORD_LEN-1:0] val2;
  logic                mthi;
  logic                mtlo;
  logic [WORD_LEN-1:0] wdata;
  logic                busy;
  logic                done;
  logic [WORD_LEN-1:0] hi;
  logic [WORD_LEN-1:0] lo;

  modport master (
    output start, op, val1, val2, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, val1, val2, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO pair.
// One bit per cycle on magnitudes; signs are applied once in FINISH.
module mult_div_unit #(
  parameter int unsigned WORD_LEN = 32
) (
  input logic            clock,
  input logic            reset,
  mult_div_unit_if.slave bus
);
  localparam int unsigned W  = WORD_LEN;
  localparam int unsigned CW = $clog2(WORD_LEN);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic [W-1:0]    orig_q, orig_d;
  logic [1:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic            dz_q, dz_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            done_q, done_d;

  logic            is_signed, s1, s2;
  logic [W-1:0]    mag1, mag2;
  logic [W-1:0]    mul_add;
  logic [W:0]      mul_sum;
  logic [W:0]      div_shift, div_diff;
  logic            div_ge;
  logic [2*W-1:0]  prod_res;
  logic [W-1:0]    quo_res, rem_res;

  assign is_signed = ~bus.op[0];
  assign s1        = is_signed & bus.val1[W-1];
  assign s2        = is_signed & bus.val2[W-1];
  assign mag1      = s1 ? -bus.val1 : bus.val1;
  assign mag2      = s2 ? -bus.val2 : bus.val2;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign mul_add   = acc_q[0] ? opnd_q : '0;
  assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, mul_add};

  // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
  assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = div_shift >= {1'b0, opnd_q};

  assign prod_res  = neg_q  ? -acc_q         : acc_q;
  assign quo_res   = neg_q  ? -acc_q[W-1:0]  : acc_q[W-1:0];
  assign rem_res   = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      orig_q  <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      orig_q  <= orig_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    orig_d  = orig_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          neg_d   = s1 ^ s2;
          rneg_d  = s1;
          orig_d  = bus.val1;
          dz_d    = (bus.val2 == '0);
          cnt_d   = '0;
          if (bus.op[1]) begin
            acc_d  = {{W{1'b0}}, mag1};
            opnd_d = mag2;
          end else begin
            acc_d  = {{W{1'b0}}, mag2};
            opnd_d = mag1;
          end
          state_d = CALC;
        end else begin
          if (bus.mthi) hi_d = bus.wdata;
          if (bus.mtlo) lo_d = bus.wdata;
        end
      end

      CALC: begin
        if (op_q[1]) begin
          acc_d = div_ge ? {div_diff[W-1:0], acc_q[W-2:0], 1'b1}
                         : {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[W-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = FINISH;
      end

      FINISH: begin
        if (op_q[1]) begin
          // Divide by zero reports the dividend as written, not its magnitude.
          if (dz_q) begin
            lo_d = '1;
            hi_d = orig_q;
          end else begin
            lo_d = quo_res;
            hi_d = rem_res;
          end
        end else begin
          {hi_d, lo_d} = prod_res;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: stimulus pushes expected HI/LO into a
// queue, an independent monitor pops and compares on every done pulse.
module tb_mult_div_unit;
  localparam int unsigned W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mult_div_unit_if #(.WORD_LEN(W)) bus ();

  mult_div_unit #(.WORD_LEN(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int done_expected = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (bus.done === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        check("result_hi", bus.hi, e[2*W-1:W]);
        check("result_lo", bus.lo, e[W-1:0]);
      end
    end
  end

  // poke_at > 0: at that CALC cycle assert either mthi (poke_start=0) or a second start.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input bit with_mtlo, input int unsigned poke_at, input bit poke_start);
    int unsigned n;
    logic [W-1:0] hold_hi, hold_lo;
    @(negedge clock);
    hold_hi   = bus.hi;
    hold_lo   = bus.lo;
    bus.start = 1'b1;
    bus.op    = op;
    bus.val1  = a;
    bus.val2  = b;
    bus.mtlo  = with_mtlo;
    bus.wdata = 32'h5555_5555;
    exp_q.push_back({ehi, elo});
    done_expected++;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.mtlo  = 1'b0;
    check("busy_after_start", {31'b0, bus.busy}, 32'd1);
    check("lo_hold_after_start", bus.lo, hold_lo);
    n = 0;
    while (bus.done !== 1'b1 && n < 60) begin
      if (poke_at != 0 && n == poke_at) begin
        if (poke_start) begin
          bus.start = 1'b1;
          bus.op    = 2'b01;
          bus.val1  = 32'd9;
          bus.val2  = 32'd9;
        end else begin
          bus.mthi  = 1'b1;
          bus.wdata = 32'hDEAD_BEEF;
        end
      end
      @(posedge clock); #1;
      n++;
      if (poke_at != 0 && n == poke_at + 1) begin
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        check("hi_hold_mid_calc", bus.hi, hold_hi);
        check("busy_mid_calc", {31'b0, bus.busy}, 32'd1);
      end
    end
    check("latency", n, 32'd33);
    check("busy_after_done", {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.val1  = '0;
    bus.val2  = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    check("reset_busy", {31'b0, bus.busy}, 32'd0);
    check("reset_done", {31'b0, bus.done}, 32'd0);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 0, 0, 0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 0);
    run_op(2'b11, 32'd100,       32'd7,        32'd2,         32'd14,        0, 0, 0);
    run_op(2'b11, 32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF, 0, 0, 0);
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 0, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 0, 0, 0);

    // MTHI alone, then MTHI+MTLO together, while idle
    @(negedge clock);
    bus.mthi  = 1'b1;
    bus.wdata = 32'h0000_1234;
    @(posedge clock); #1;
    bus.mthi  = 1'b0;
    check("mthi_hi", bus.hi, 32'h0000_1234);
    check("mthi_lo_untouched", bus.lo, 32'h8000_0000);
    check("mthi_no_done", {31'b0, bus.done}, 32'd0);
    @(negedge clock);
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h0000_A5A5;
    @(posedge clock); #1;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    check("mthilo_hi", bus.hi, 32'h0000_A5A5);
    check("mthilo_lo", bus.lo, 32'h0000_A5A5);
    check("mthilo_no_done", {31'b0, bus.done}, 32'd0);

    // start + mtlo collision, mid-CALC mthi, mid-CALC second start
    run_op(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1, 0, 0);
    run_op(2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 0, 5, 0);
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0, 7, 1);

    // Reset ten cycles into a DIV: no result, everything cleared
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.val1  = 32'hFFFF_FFF9;
    bus.val2  = 32'd2;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    repeat (40) @(posedge clock);

    run_op(2'b10, 32'd1000, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FEB3, 0, 0, 0);

    repeat (3) @(posedge clock);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    check("done_count", done_seen, done_expected);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit that produces the HI/LO register pair consumed by the EX-stage ALU's MFHI/MFLO commands.
- Sits beside the ALU in EX and owns the architectural HI and LO registers.
- Accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO from decode and exposes busy so the hazard unit can stall.
- Shift-add multiply and restoring divide, one bit per cycle.

Parameters:
WORD_LEN, 32, operand, HI and LO width (matches `WORD_LEN).

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  launch operation selected by op, sampled only when busy=0
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
val1  input  WORD_LEN  multiplicand / dividend (rs)
val2  input  WORD_LEN  multiplier / divisor (rt)
mthi  input  1  write wdata to HI
mtlo  input  1  write wdata to LO
wdata  input  WORD_LEN  data for MTHI/MTLO
busy  output  1  operation in flight; hazard unit stalls MFHI/MFLO/MULT/DIV/MTHI/MTLO
done  output  1  one-cycle pulse, HI/LO just updated with a result
hi  output  WORD_LEN  HI register
lo  output  WORD_LEN  LO register

Behaviour:
- Reset (edge with reset=1, highest priority, also aborts mid-operation):
  - hi=0, lo=0, busy=0, done=0.
  - FSM to IDLE; iteration counter and working registers cleared.
- FSM states: IDLE, CALC, FINISH.
- IDLE, start=1 at edge E0:
  - Latch op.
  - Latch magnitudes |val1|, |val2| (signed ops) or raw values (unsigned ops).
  - Latch result signs: product sign = s1^s2; quotient sign = s1^s2; remainder sign = s1.
  - Counter=0; go to CALC; busy=1 from E0.
- CALC: one iteration per edge, WORD_LEN edges (E1..E32).
  - Multiply: 2*WORD_LEN-bit accumulator, add-shift on multiplier LSB.
  - Divide: restoring shift-subtract, quotient bit 1 if partial remainder >= divisor.
  - After the WORD_LEN-th iteration, go to FINISH.
- FINISH (edge E33):
  - Apply sign correction (two's-complement negate where the sign bit is 1).
  - Write hi/lo, done=1 for exactly this cycle, busy=0, back to IDLE.
  - Total latency: start sample to result visible = 33 edges; busy high 33 cycles.
- Results:
  - MULT/MULTU: {hi,lo} = full 64-bit product.
  - DIV/DIVU: lo = quotient, truncated toward zero; hi = remainder, sign follows dividend.
- Divide by zero (val2=0, either signedness):
  - Full 33-cycle latency.
  - lo=all ones, hi=val1 as latched (original signed value for DIV).
  - No exception signalled.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- MTHI/MTLO:
  - Write on the edge when busy=0 and start=0.
  - mthi and mtlo together write both registers.
  - While busy=1 both are ignored; the hazard unit must stall them.
- Collisions:
  - start with mthi/mtlo in the same IDLE cycle: start wins, the write is dropped.
  - start while busy=1 is ignored; the current op is not disturbed.
- hi/lo hold their value throughout CALC; the old values stay readable until FINISH.
- done never asserts for MTHI/MTLO.

Test Plan:
- Reset, then MULT val1=0xFFFFFFFD (−3), val2=7 -> busy 33 cycles, done pulse once, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 2 -> hi=0x00000001, lo=0xFFFFFFFE; then MULT same operands -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- DIV −7 (0xFFFFFFF9) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100 / 7 -> lo=14, hi=2.
- DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x1234 while idle -> hi=0x1234 next edge, done stays 0; start MULT 3×4 with mtlo=1 same cycle -> mtlo dropped, final lo=12, hi=0; mthi asserted mid-CALC -> ignored.
- Start DIV, assert reset at cycle 10 of CALC -> next edge hi=lo=0, busy=0, no done pulse; new start afterwards completes normally in 33 cycles.
